// File: rtl/hdmi_pkg.sv
// Shared HDMI video definitions: 720p timing defaults, the 24-bit pixel type and the
// transmit FSM state encoding.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StStream
  } tx_state_e;

endpackage

// File: rtl/hdmi_timing_gen.sv
// Free-running raster counters with sync, active-area and top-left window flags, all
// combinational from the current counter state.
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned WIN_W    = 64,
  parameter int unsigned WIN_H    = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_active,
  output logic o_window,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_frame_first,
  output logic o_frame_last
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  int unsigned   w_h;
  int unsigned   w_v;
  logic          w_h_last;

  // Widen to 32 bits so every window/sync bound compares without truncation.
  assign w_h      = 32'(r_h_cnt);
  assign w_v      = 32'(r_v_cnt);
  assign w_h_last = (r_h_cnt == H_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  always_comb begin
    o_active      = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    o_window      = o_active && (w_h < WIN_W) && (w_v < WIN_H);
    o_hsync       = ((w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC)) ?
                    SYNC_POL : ~SYNC_POL;
    o_vsync       = ((w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC)) ?
                    SYNC_POL : ~SYNC_POL;
    o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
    o_frame_last  = w_h_last && (r_v_cnt == V_LAST);
  end

endmodule

// File: rtl/hdmi_tx_video_gen.sv
// HDMI transmit video source: raster timing plus a FIFO-fed window at the top-left of the
// active area, background elsewhere, with a fixed two-cycle output pipeline.
module hdmi_tx_video_gen
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned WIN_W    = 64,
  parameter int unsigned WIN_H    = 64,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_read,
  input  logic [23:0] fifo_data_out,
  input  logic        fifo_empty,
  output logic        fifo_read_enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        underflow
);

  logic      w_active;
  logic      w_window;
  logic      w_hsync;
  logic      w_vsync;
  logic      w_first;
  logic      w_last;
  logic      w_win_stream;
  tx_state_e r_state;
  tx_state_e w_state_d;

  logic      r_s1_de;
  logic      r_s1_hsync;
  logic      r_s1_vsync;
  logic      r_s1_win_stream;
  logic      r_s1_rd;
  logic      r_s1_first;

  pixel_t    r_pix;
  pixel_t    w_pix_d;
  logic      w_uf_hit;

  hdmi_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H)
  ) u_timing (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_active      (w_active),
    .o_window      (w_window),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_first (w_first),
    .o_frame_last  (w_last)
  );

  assign w_win_stream     = (r_state == StStream) && w_window;
  assign fifo_read_enable = w_win_stream && !fifo_empty;

  // Mode changes only take effect on the last counter cycle of a frame.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (start_read) w_state_d = StArmed;
      StArmed: begin
        if (!start_read)  w_state_d = StIdle;
        else if (w_last)  w_state_d = StStream;
      end
      StStream: if (w_last && !start_read) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_s1_de         <= 1'b0;
      r_s1_hsync      <= ~SYNC_POL;
      r_s1_vsync      <= ~SYNC_POL;
      r_s1_win_stream <= 1'b0;
      r_s1_rd         <= 1'b0;
      r_s1_first      <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_s1_de         <= w_active;
      r_s1_hsync      <= w_hsync;
      r_s1_vsync      <= w_vsync;
      r_s1_win_stream <= w_win_stream;
      r_s1_rd         <= fifo_read_enable;
      r_s1_first      <= w_first;
    end
  end

  // A window slot with no read means the FIFO was empty; the slot is never refilled later.
  always_comb begin
    w_pix_d  = '0;
    w_uf_hit = 1'b0;
    if (r_s1_rd) begin
      w_pix_d = pixel_t'(fifo_data_out);
    end else if (r_s1_win_stream) begin
      w_pix_d  = pixel_t'(BG_COLOR);
      w_uf_hit = 1'b1;
    end else if (r_s1_de) begin
      w_pix_d = pixel_t'(BG_COLOR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      r_pix       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      hsync       <= r_s1_hsync;
      vsync       <= r_s1_vsync;
      de          <= r_s1_de;
      r_pix       <= w_pix_d;
      frame_start <= r_s1_first;
      underflow   <= underflow | w_uf_hit;
    end
  end

  assign red   = r_pix.r;
  assign green = r_pix.g;
  assign blue  = r_pix.b;

endmodule

// File: tb/tb_hdmi_tx_video_gen.sv
// Scoreboard bench for hdmi_tx_video_gen on a tiny raster: a frame-level reference model
// predicts every output cycle; a forked monitor compares them against the DUT.
module tb_hdmi_tx_video_gen;

  localparam int unsigned H_ACT  = 8;
  localparam int unsigned H_FP   = 2;
  localparam int unsigned H_SYNC = 2;
  localparam int unsigned H_BP   = 2;
  localparam int unsigned V_ACT  = 4;
  localparam int unsigned V_FP   = 1;
  localparam int unsigned V_SYNC = 1;
  localparam int unsigned V_BP   = 1;
  localparam int unsigned WIN_W  = 4;
  localparam int unsigned WIN_H  = 2;
  localparam bit          SYNC_POL = 1'b1;
  localparam logic [23:0] BG     = 24'h123456;
  localparam int          HT     = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int          VT     = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int          FRAME  = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        fs;
    logic        uf;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_read;
  logic [23:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_read_enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic        underflow;

  hdmi_tx_video_gen #(
    .H_ACTIVE (H_ACT),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H),
    .BG_COLOR (BG)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_read       (start_read),
    .fifo_data_out    (fifo_data_out),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .hsync            (hsync),
    .vsync            (vsync),
    .de               (de),
    .red              (red),
    .green            (green),
    .blue             (blue),
    .frame_start      (frame_start),
    .underflow        (underflow)
  );

  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          n_de;
  int          n_hs;
  int          n_vs;
  int          n_reads;
  int          mon_cyc;
  bit          mon_en;
  bit          rd_prev;

  logic [23:0] fifo_q[$];   // the FIFO the DUT reads from
  logic [23:0] mdl_q[$];    // the model's view of which words are still to be shown
  out_t        exp_q[$];
  logic        rd_exp_q[$];

  int          cyc;
  bit          m_stream;
  bit          m_prev_start;
  bit          m_uf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t idle_out();
    out_t o;
    o.hs  = !SYNC_POL;
    o.vs  = !SYNC_POL;
    o.de  = 1'b0;
    o.rgb = 24'h0;
    o.fs  = 1'b0;
    o.uf  = 1'b0;
    return o;
  endfunction

  // Reference: raster position from the cycle number, window words in load order, and a
  // frame streams when start_read was high on the last two cycles of the previous frame
  // (or on its last cycle while already streaming).
  task automatic model_step();
    int   h;
    int   v;
    bit   act;
    bit   win;
    bit   rd;
    out_t e;
    h   = cyc % HT;
    v   = (cyc / HT) % VT;
    act = (h < H_ACT) && (v < V_ACT);
    win = act && (h < WIN_W) && (v < WIN_H);
    rd  = m_stream && win && (mdl_q.size() > 0);
    e.hs = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    e.vs = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    e.de = act;
    e.fs = (h == 0) && (v == 0);
    if (rd) begin
      e.rgb = mdl_q.pop_front();
    end else if (m_stream && win) begin
      e.rgb = BG;
      m_uf  = 1'b1;
    end else begin
      e.rgb = act ? BG : 24'h0;
    end
    e.uf = m_uf;
    exp_q.push_back(e);
    rd_exp_q.push_back(rd);
    if (h == HT - 1 && v == VT - 1) m_stream = start_read && (m_stream || m_prev_start);
    m_prev_start = start_read;
    cyc++;
  endtask

  task automatic monitor();
    out_t a;
    out_t e;
    logic r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = {hsync, vsync, de, red, green, blue, frame_start, underflow};
        if (exp_q.size() == 0 || rd_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: no expected entry at out cycle %0d", mon_cyc);
        end else begin
          e = exp_q.pop_front();
          r = rd_exp_q.pop_front();
          chk($sformatf("out@%0d {hs,vs,de,rgb,fs,uf}", mon_cyc), 32'(a), 32'(e));
          chk($sformatf("fifo_read_enable@%0d", mon_cyc), 32'(fifo_read_enable), 32'(r));
        end
        n_de    += int'(de);
        n_hs    += int'(hsync);
        n_vs    += int'(vsync);
        n_reads += int'(fifo_read_enable);
        mon_cyc++;
      end
    end
  endtask

  // Called at posedge+1 of the cycle being modelled; returns at posedge+1 of the next one.
  task automatic cycle();
    fifo_empty = (fifo_q.size() == 0);
    model_step();
    @(negedge clk);
    rd_prev = fifo_read_enable;
    @(posedge clk);
    #1;
    if (rd_prev) fifo_data_out = (fifo_q.size() > 0) ? fifo_q.pop_front() : 24'hBAD0BD;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_frame();
    int guard;
    guard = 0;
    while ((cyc % FRAME) != 0 && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    if ((cyc % FRAME) != 0) chk("frame_boundary_timeout", 32'(guard), 32'(0));
  endtask

  task automatic load(input logic [23:0] w);
    fifo_q.push_back(w);
    mdl_q.push_back(w);
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) load(24'($urandom));
  endtask

  task automatic release_reset();
    rst          = 1'b0;
    cyc          = 0;
    m_stream     = 1'b0;
    m_prev_start = 1'b0;
    m_uf         = 1'b0;
    rd_prev      = 1'b0;
    exp_q.delete();
    rd_exp_q.delete();
    exp_q.push_back(idle_out());
    exp_q.push_back(idle_out());
    mon_en       = 1'b1;
  endtask

  int b_de;
  int b_hs;
  int b_vs;
  int b_rd;

  initial begin
    rst           = 1'b1;
    start_read    = 1'b0;
    fifo_data_out = 24'h0;
    fifo_empty    = 1'b1;
    mon_en        = 1'b0;
    n_checks      = 0;
    n_fail        = 0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Idle timing over two whole frames.
    run_until_frame();
    b_de = n_de; b_hs = n_hs; b_vs = n_vs; b_rd = n_reads;
    run(2 * FRAME);
    chk("idle_de_cycles",    32'(n_de - b_de),    32'(2 * H_ACT * V_ACT));
    chk("idle_hsync_cycles", 32'(n_hs - b_hs),    32'(2 * H_SYNC * VT));
    chk("idle_vsync_cycles", 32'(n_vs - b_vs),    32'(2 * V_SYNC * HT));
    chk("idle_reads",        32'(n_reads - b_rd), 32'(0));

    // Stream a full window 1..8, drop start_read on line 2.
    for (int i = 1; i <= 8; i++) load(24'(i));
    run(30);
    start_read = 1'b1;
    run_until_frame();
    b_rd = n_reads;
    run(40);
    start_read = 1'b0;
    run(FRAME - 40);
    chk("stream_reads",     32'(n_reads - b_rd),   32'(WIN_W * WIN_H));
    chk("stream_fifo_left", 32'(fifo_q.size()),    32'(0));
    chk("stream_underflow", 32'(underflow),        32'(0));

    // Only five words: last three window pixels underflow.
    load_rand(5);
    run(30);
    start_read = 1'b1;
    run_until_frame();
    b_rd = n_reads;
    run(40);
    start_read = 1'b0;
    run(FRAME - 40);
    chk("short_reads",     32'(n_reads - b_rd), 32'(5));
    chk("short_underflow", 32'(underflow),      32'(1));

    // Drop start_read during line 2; this frame completes, the next is background only.
    load_rand(8);
    run(30);
    start_read = 1'b1;
    run_until_frame();
    b_rd = n_reads;
    run(2 * HT + 3);
    start_read = 1'b0;
    run(FRAME - (2 * HT + 3));
    chk("stop_frame_reads", 32'(n_reads - b_rd), 32'(WIN_W * WIN_H));
    load_rand(4);
    b_rd = n_reads;
    run(FRAME);
    chk("after_stop_reads",     32'(n_reads - b_rd), 32'(0));
    chk("after_stop_fifo_left", 32'(fifo_q.size()),  32'(4));

    // Random start_read toggles and FIFO refills at arbitrary cycles.
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(39) == 0) start_read = !start_read;
      if ($urandom_range(29) == 0) load_rand(int'($urandom_range(6, 1)));
      cycle();
    end
    start_read = 1'b0;
    run(2 * FRAME);

    // Asynchronous reset between clock edges, mid-line.
    run(20);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("rst_de",          32'(de),               32'(0));
    chk("rst_hsync",       32'(hsync),            32'(!SYNC_POL));
    chk("rst_vsync",       32'(vsync),            32'(!SYNC_POL));
    chk("rst_rgb",         {8'h0, red, green, blue}, 32'(0));
    chk("rst_frame_start", 32'(frame_start),      32'(0));
    chk("rst_underflow",   32'(underflow),        32'(0));
    chk("rst_read_enable", 32'(fifo_read_enable), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    release_reset();
    cycle();
    chk("post_rst_fs_cycle1", 32'(frame_start), 32'(0));
    cycle();
    chk("post_rst_fs_cycle2", 32'(frame_start), 32'(1));
    chk("post_rst_de_cycle2", 32'(de),          32'(1));
    run(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
